// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer: arms on AL_ON, rings on a time-match edge, handles
// user stop, a bounded number of snoozes, and a ring timeout that leaves a
// sticky "missed" flag. Runs on the slow system clock.
module alarm_ring_ctrl #(
    parameter int TICKS_PER_SEC = 10,
    parameter int RING_SEC      = 60,
    parameter int SNOOZE_SEC    = 300,
    parameter int MAX_SNOOZE    = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             AL_ON,
    input  logic                             STOP_al,
    input  logic                             SNOOZE,
    input  logic                             time_match,
    output logic                             Alarm,
    output logic                             snoozing,
    output logic [$clog2(MAX_SNOOZE+1)-1:0]  snooze_cnt,
    output logic                             missed
);

    localparam int RING_N = RING_SEC * TICKS_PER_SEC;
    localparam int SNZ_N  = SNOOZE_SEC * TICKS_PER_SEC;
    localparam int MAX_N  = (RING_N > SNZ_N) ? RING_N : SNZ_N;
    localparam int TW     = $clog2(MAX_N);
    localparam int CW     = $clog2(MAX_SNOOZE + 1);

    typedef enum logic [1:0] {S_OFF, S_ARMED, S_RINGING, S_SNOOZE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            missed_q, missed_d;
    logic            alarm_q, alarm_d;
    logic            snoozing_q, snoozing_d;
    logic            match_q;
    logic            match_edge;
    logic            ring_exp;
    logic            snz_exp;

    // Next-state, counters and output decode; priority ladder from AL_ON down.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        missed_d   = missed_q;
        match_edge = time_match & ~match_q;
        ring_exp   = (timer_q == TW'(RING_N - 1));
        snz_exp    = (timer_q == TW'(SNZ_N - 1));

        if (!AL_ON) begin
            state_d  = S_OFF;
            cnt_d    = '0;
            missed_d = 1'b0;
        end else if (STOP_al) begin
            // STOP holds OFF in OFF; anything active falls back to ARMED.
            if (state_q != S_OFF) state_d = S_ARMED;
            cnt_d    = '0;
            missed_d = 1'b0;
        end else begin
            case (state_q)
                S_OFF:     state_d = S_ARMED;
                S_ARMED:   if (match_edge) state_d = S_RINGING;
                S_RINGING: begin
                    if (SNOOZE && (cnt_q < CW'(MAX_SNOOZE))) begin
                        state_d = S_SNOOZE;
                        cnt_d   = cnt_q + CW'(1);
                    end else if (ring_exp) begin
                        state_d  = S_ARMED;
                        missed_d = 1'b1;
                        cnt_d    = '0;
                    end
                end
                S_SNOOZE:  if (snz_exp) state_d = S_RINGING;
                default:   state_d = S_OFF;
            endcase
        end

        // Timer restarts on every state change and only runs in timed states.
        if (state_d != state_q)
            timer_d = '0;
        else if (state_q == S_RINGING || state_q == S_SNOOZE)
            timer_d = timer_q + TW'(1);
        else
            timer_d = '0;

        alarm_d    = (state_d == S_RINGING);
        snoozing_d = (state_d == S_SNOOZE);
    end

    // State, timer and registered outputs; match_q tracks time_match always.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_OFF;
            timer_q    <= '0;
            cnt_q      <= '0;
            missed_q   <= 1'b0;
            alarm_q    <= 1'b0;
            snoozing_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            missed_q   <= missed_d;
            alarm_q    <= alarm_d;
            snoozing_q <= snoozing_d;
            match_q    <= time_match;
        end
    end

    assign Alarm      = alarm_q;
    assign snoozing   = snoozing_q;
    assign snooze_cnt = cnt_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl: a vector table for single-cycle
// behaviour plus hand sequences for ring timeout, snooze timing and reset.
module tb_alarm_ring_ctrl;

    logic       clk = 1'b0;
    logic       reset, AL_ON, STOP_al, SNOOZE, time_match;
    logic       Alarm, snoozing, missed;
    logic [1:0] snooze_cnt;

    int checks = 0;
    int errors = 0;

    alarm_ring_ctrl dut (
        .clk(clk), .reset(reset), .AL_ON(AL_ON), .STOP_al(STOP_al),
        .SNOOZE(SNOOZE), .time_match(time_match), .Alarm(Alarm),
        .snoozing(snoozing), .snooze_cnt(snooze_cnt), .missed(missed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       al_on, stop, snz, tm;
        logic [4:0] exp;   // {Alarm, snoozing, snooze_cnt[1:0], missed}
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic a, s, z, t, input logic [4:0] e);
        vec_t v;
        v.al_on = a; v.stop = s; v.snz = z; v.tm = t; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({Alarm, snoozing, snooze_cnt, missed});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; AL_ON = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0; time_match = 1'b0;
        step();
        check("reset_outputs", outs(), 0);
        reset = 1'b0;
    endtask

    // From ARMED: produce a fresh match edge and expect ringing.
    task automatic ring_up(input string name);
        time_match = 1'b0; step();
        time_match = 1'b1; step();
        check(name, int'(Alarm), 1);
    endtask

    // One snooze pulse from RINGING; the pause must last exactly 3000 cycles.
    task automatic snooze_cycle(input int exp_cnt);
        int n;
        SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
        check($sformatf("snooze%0d_enter", exp_cnt), outs(), (1 << 3) | (exp_cnt << 1));
        n = 0;
        while (snoozing && n < 3100) begin n++; step(); end
        check($sformatf("snooze%0d_len", exp_cnt), n, 3000);
        check($sformatf("snooze%0d_rering", exp_cnt), outs(), (1 << 4) | (exp_cnt << 1));
    endtask

    initial begin
        int n, bad;

        vecs[0]  = mk(1, 0, 0, 0, 5'b00000);
        vecs[1]  = mk(1, 0, 0, 1, 5'b10000);
        vecs[2]  = mk(1, 0, 1, 1, 5'b01010);
        vecs[3]  = mk(1, 0, 1, 1, 5'b01010);
        vecs[4]  = mk(1, 1, 1, 1, 5'b00000);
        vecs[5]  = mk(1, 0, 0, 1, 5'b00000);
        vecs[6]  = mk(1, 0, 0, 0, 5'b00000);
        vecs[7]  = mk(1, 0, 0, 1, 5'b10000);
        vecs[8]  = mk(1, 1, 1, 1, 5'b00000);
        vecs[9]  = mk(1, 0, 0, 0, 5'b00000);
        vecs[10] = mk(1, 0, 0, 1, 5'b10000);
        vecs[11] = mk(1, 0, 1, 1, 5'b01010);
        vecs[12] = mk(0, 0, 0, 1, 5'b00000);
        vecs[13] = mk(1, 0, 0, 1, 5'b00000);
        vecs[14] = mk(1, 0, 0, 1, 5'b00000);
        vecs[15] = mk(1, 0, 0, 0, 5'b00000);
        vecs[16] = mk(1, 0, 0, 1, 5'b10000);
        vecs[17] = mk(0, 0, 0, 1, 5'b00000);
        vecs[18] = mk(1, 1, 0, 0, 5'b00000);
        vecs[19] = mk(1, 0, 0, 1, 5'b00000);
        vecs[20] = mk(1, 0, 0, 1, 5'b00000);
        vecs[21] = mk(1, 0, 0, 0, 5'b00000);
        vecs[22] = mk(1, 0, 0, 1, 5'b10000);
        vecs[23] = mk(1, 0, 1, 0, 5'b01010);
        vecs[24] = mk(1, 0, 0, 1, 5'b01010);
        vecs[25] = mk(1, 1, 0, 1, 5'b00000);

        reset = 1'b1; AL_ON = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0; time_match = 1'b0;
        step(); step();
        check("initial_reset", outs(), 0);
        reset = 1'b0;

        // Table: one clock per row.
        for (int i = 0; i < 26; i++) begin
            AL_ON = vecs[i].al_on; STOP_al = vecs[i].stop;
            SNOOZE = vecs[i].snz;  time_match = vecs[i].tm;
            step();
            check($sformatf("vec%0d", i), outs(), int'(vecs[i].exp));
        end

        // Ring at cycle 11, stop at 50, time_match held 600 cycles: no re-ring.
        apply_reset();
        AL_ON = 1'b1;
        repeat (10) step();
        time_match = 1'b1; step();
        check("t1_ring_latency", int'(Alarm), 1);
        bad = 0;
        repeat (39) begin step(); if (!Alarm) bad++; end
        check("t1_ring_held", bad, 0);
        STOP_al = 1'b1; step(); STOP_al = 1'b0;
        check("t1_stop", outs(), 0);
        bad = 0;
        repeat (600) begin step(); if (Alarm) bad++; end
        check("t1_no_rering", bad, 0);

        // Ring timeout: exactly 600 cycles, then missed and back to ARMED.
        ring_up("t2_ring");
        n = 0;
        while (Alarm && n < 700) begin n++; step(); end
        check("t2_ring_len", n, 600);
        check("t2_timeout_outs", outs(), 5'b00001);
        ring_up("t2_rearmed_ring");
        check("t2_missed_kept", int'(missed), 1);
        STOP_al = 1'b1; step(); STOP_al = 1'b0;
        check("t2_stop_clears", outs(), 0);

        // Three snoozes, fourth ignored.
        ring_up("t3_ring");
        for (int k = 1; k <= 3; k++) snooze_cycle(k);
        SNOOZE = 1'b1; step(); SNOOZE = 1'b0;
        check("t3_fourth_ignored", outs(), 5'b10110);
        STOP_al = 1'b1; step(); STOP_al = 1'b0;
        check("t3_stop", outs(), 0);

        // Async reset mid-ring with two snoozes used.
        ring_up("t6_ring");
        for (int k = 1; k <= 2; k++) snooze_cycle(k);
        #3 reset = 1'b1;
        #1 check("t6_async_reset", outs(), 0);
        #2 reset = 1'b0;
        step();
        check("t6_first_cycle", outs(), 0);
        ring_up("t6_armed_after_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
